// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//   Multi-cycle MUL / DIVU / REMU sequencer that borrows the core's shared
//   32-bit ALU. There is no multiplier or divider array. Every add, subtract
//   and compare goes through the ALU, driven via the datapath operand mux
//   while alu_own is high.
//
//   MUL  : shift-add, 32 ADD steps, done in cycle 33 (low 32 bits only).
//   DIVU : restoring division, 32 x (SLTU compare, SUB) = 64 cycles,
//          done in cycle 65.
//   REMU : same as DIVU, returns the remainder.
//   Divide-by-zero and the reserved op finish in cycle 1 without using the
//   ALU.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   request pulse, sampled only in IDLE
//   op[1:0]    in   00 MUL, 01 DIVU, 10 REMU, 11 reserved
//   opa, opb   in   operands, latched with start
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//   result     out  final value, held until the next accepted start
//   alu_own    out  datapath selects alu_ctrl/alu_a/alu_b when high
//   alu_ctrl   out  ALU control code
//   alu_a      out  ALU SrcA
//   alu_b      out  ALU SrcB
//   alu_result in   combinational ALU result for the current operands
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
   parameter int         WIDTH    = 32,
   parameter logic [4:0] ALU_ADD  = 5'b00000,
   parameter logic [4:0] ALU_SUB  = 5'b00001,
   parameter logic [4:0] ALU_SLTU = 5'b01000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             alu_own,
   output logic [4:0]       alu_ctrl,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_result
);

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REMU = 2'b10;
   localparam logic [5:0] LAST    = 6'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_STEP,
      S_DIV_CMP,
      S_DIV_SUB,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             take_q, take_d;
   logic [WIDTH-1:0] result_q, result_d;

   // Partial remainder shifted left by one with the next dividend bit
   // brought in from the top of quo. The bit shifted out of rem (msb) means
   // the true value is >= 2^32, so it always exceeds the divisor.
   logic [WIDTH-1:0] r_shift;
   logic             r_msb;
   assign r_shift = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
   assign r_msb   = rem_q[WIDTH-1];

   // Next-iteration values, used for both the register update and the
   // final result on the last step.
   logic [WIDTH-1:0] acc_nx, rem_nx, quo_nx;
   assign acc_nx = mplier_q[0] ? alu_result : acc_q;
   // With take set, r_shift >= divisor (counting the lost msb), so the
   // mod-2^32 difference from the ALU is the exact remainder.
   assign rem_nx = take_q ? alu_result : r_shift;
   assign quo_nx = {quo_q[WIDTH-2:0], take_q};

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;
      take_d   = take_q;
      result_d = result_q;
      busy     = (state_q != S_IDLE);
      done     = 1'b0;
      alu_own  = 1'b0;
      alu_ctrl = '0;
      alu_a    = '0;
      alu_b    = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d     = op;
               cnt_d    = '0;
               acc_d    = '0;
               mcand_d  = opa;
               mplier_d = opb;
               rem_d    = '0;
               quo_d    = opa;
               dvsr_d   = opb;
               take_d   = 1'b0;
               case (op)
                  OP_MUL: state_d = S_MUL_STEP;
                  OP_DIVU: begin
                     if (opb != '0) begin
                        state_d = S_DIV_CMP;
                     end else begin
                        state_d  = S_DONE;
                        result_d = '1;
                     end
                  end
                  OP_REMU: begin
                     if (opb != '0) begin
                        state_d = S_DIV_CMP;
                     end else begin
                        state_d  = S_DONE;
                        result_d = opa;
                     end
                  end
                  default: begin
                     state_d  = S_DONE;
                     result_d = '0;
                  end
               endcase
            end
         end

         S_MUL_STEP: begin
            alu_own  = 1'b1;
            alu_ctrl = ALU_ADD;
            alu_a    = acc_q;
            alu_b    = mcand_q;
            acc_d    = acc_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == LAST) begin
               state_d  = S_DONE;
               result_d = acc_nx;
            end
         end

         S_DIV_CMP: begin
            alu_own  = 1'b1;
            alu_ctrl = ALU_SLTU;
            alu_a    = r_shift;
            alu_b    = dvsr_q;
            take_d   = r_msb | ~alu_result[0];
            state_d  = S_DIV_SUB;
         end

         S_DIV_SUB: begin
            alu_own  = 1'b1;
            alu_ctrl = ALU_SUB;
            alu_a    = r_shift;
            alu_b    = dvsr_q;
            rem_d    = rem_nx;
            quo_d    = quo_nx;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == LAST) begin
               state_d  = S_DONE;
               result_d = (op_q == OP_REMU) ? rem_nx : quo_nx;
            end else begin
               state_d = S_DIV_CMP;
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         take_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         take_q   <= take_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [1:0]  op;
   logic [31:0] opa, opb;
   logic        busy, done, alu_own;
   logic [31:0] result, alu_a, alu_b, alu_result;
   logic [4:0]  alu_ctrl;

   alu_muldiv_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
      .busy(busy), .done(done), .result(result), .alu_own(alu_own),
      .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result)
   );

   // Shared core ALU
   always_comb begin
      case (alu_ctrl)
         5'b00000: alu_result = alu_a + alu_b;
         5'b00001: alu_result = alu_a - alu_b;
         5'b01000: alu_result = {31'b0, (alu_a < alu_b)};
         default:  alu_result = 32'h0;
      endcase
   end

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          lat;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      case (o)
         2'b00: begin e.res = a * b; e.lat = 33; end
         2'b01: begin e.res = (b == 0) ? 32'hFFFFFFFF : a / b; e.lat = (b == 0) ? 1 : 65; end
         2'b10: begin e.res = (b == 0) ? a : a % b; e.lat = (b == 0) ? 1 : 65; end
         default: begin e.res = 32'h0; e.lat = 1; end
      endcase
      sb.push_back(e);
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_own"}, alu_own, 0);
      chk({tag, "_ctrl"}, alu_ctrl, 0);
      chk({tag, "_a"}, alu_a, 0);
      chk({tag, "_b"}, alu_b, 0);
   endtask

   // Issue one op in the current cycle and follow it to completion.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit chk_alu);
      exp_t e;
      int   c0, rel;
      bit   seen;
      e.res = 32'h0; e.lat = 0;
      start = 1'b1; op = o; opa = a; opb = b;
      push_exp(o, a, b);
      c0 = cyc;
      tick();
      start = 1'b0; op = 2'($urandom); opa = $urandom; opb = $urandom;
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         rel = cyc - c0;
         if (done) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               chk("sb_empty", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("result", result, e.res);
               chk("latency", rel, e.lat);
               chk("busy_at_done", busy, 1);
               chk("own_at_done", alu_own, 0);
            end
         end else begin
            if (chk_alu) begin
               if (o == 2'b00)
                  chk("mul_ctrl", {alu_own, alu_ctrl}, {1'b1, 5'b00000});
               else
                  chk("div_ctrl", {alu_own, alu_ctrl},
                      rel[0] ? {1'b1, 5'b01000} : {1'b1, 5'b00001});
            end
            tick();
         end
      end
      if (!seen) chk("timeout", 0, 1);
      tick();
      chk("busy_after", busy, 0);
      chk("held", result, e.res);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0, ndone;
      reset = 1'b1; start = 1'b0; op = 2'b00; opa = 32'h0; opb = 32'h0;
      tick(); tick();
      reset = 1'b0;
      chk_idle_zero("rst");
      chk("rst_result", result, 0);

      run_op(2'b00, 32'd7, 32'd6, 1'b1);
      run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      run_op(2'b00, 32'h80000000, 32'd2, 1'b0);
      run_op(2'b01, 32'd100, 32'd7, 1'b1);
      run_op(2'b10, 32'd100, 32'd7, 1'b0);
      run_op(2'b01, 32'hFFFFFFFF, 32'h80000001, 1'b0);
      run_op(2'b10, 32'hFFFFFFFF, 32'h80000001, 1'b0);
      run_op(2'b01, 32'd5, 32'd0, 1'b0);
      run_op(2'b10, 32'd5, 32'd0, 1'b0);
      run_op(2'b11, 32'd5, 32'd9, 1'b0);
      for (int i = 0; i < 6; i++)
         run_op(2'(i % 3), $urandom, $urandom_range(1, 32'hFFFF), 1'b0);

      // Abort: MUL 3*3 in cycle 0, ignored start in 10, reset in 20.
      start = 1'b1; op = 2'b00; opa = 32'd3; opb = 32'd3;
      push_exp(2'b00, 32'd3, 32'd3);
      c0 = cyc;
      ndone = 0;
      tick();
      start = 1'b0;
      while (cyc - c0 < 20) begin
         if (done) ndone++;
         if (cyc - c0 == 10) begin
            start = 1'b1; op = 2'b01; opa = 32'd100; opb = 32'd7;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      chk("abort_busy20", busy, 1);
      chk("abort_own20", alu_own, 1);
      chk("abort_ctrl20", alu_ctrl, 5'b00000);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      chk("abort_nodone", ndone, 0);
      chk_idle_zero("abort");
      chk("abort_result", result, 0);
      tick();
      chk("abort_cyc22", cyc - c0, 22);
      run_op(2'b00, 32'd3, 32'd3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
